// File: rtl/wb_line_adapter_pkg.sv
// Shared types and geometry helpers for the single-line write-back buffer.
package wb_line_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    FILL,
    RESPOND,
    FLUSH_WB
  } state_t;

  // Byte-offset width of one line: log2 of the line size in bytes.
  function automatic int unsigned offset_bits(input int unsigned word_size);
    return $clog2(word_size / 8);
  endfunction

  // Number of address bits above the line offset.
  function automatic int unsigned tag_bits(input int unsigned word_size);
    return 32 - offset_bits(word_size);
  endfunction

endpackage

// File: rtl/wb_line_merge.sv
// Combinational byte-enable merge of one 32-bit word into a line.
module wb_line_merge
  import wb_line_adapter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 256
) (
  input  logic [WORD_SIZE-1:0]                line,
  input  logic [offset_bits(WORD_SIZE)-3:0]   word_idx,
  input  logic [3:0]                          sel,
  input  logic [31:0]                         data,
  output logic [WORD_SIZE-1:0]                merged
);

  // Overlay each enabled byte of data onto the selected word; others pass through
  always_comb begin
    merged = line;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) merged[32'(word_idx) * 32 + b * 8 +: 8] = data[b * 8 +: 8];
    end
  end

endmodule

// File: rtl/wb_line_adapter.sv
// Single-line write-back buffer between a 32-bit Wishbone-classic requester
// and the wide DRAM wrapper port. One line with tag/valid/dirty; whole-line
// write-back and fill on misses and on flush.
module wb_line_adapter
  import wb_line_adapter_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 256,
  parameter int unsigned MEM_ADDR_SHIFT = 7
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  initialized_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  ack_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  mem_cyc_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [WORD_SIZE-1:0]  mem_data_o,
  input  logic [WORD_SIZE-1:0]  mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int unsigned OFFSET = offset_bits(WORD_SIZE);
  localparam int unsigned TAG_W  = tag_bits(WORD_SIZE);
  localparam int unsigned IDX_W  = OFFSET - 2;

  state_t state, next_state;

  logic [WORD_SIZE-1:0] line;
  logic [TAG_W-1:0]     tag;
  logic                 valid, dirty, flush_pending;

  logic [31:2]          req_addr;
  logic                 req_we;
  logic [3:0]           req_sel;
  logic [31:0]          req_data;

  logic [31:2]          cur_addr;
  logic                 cur_we;
  logic [3:0]           cur_sel;
  logic [31:0]          cur_data;
  logic [TAG_W-1:0]     cur_tag;
  logic [IDX_W-1:0]     cur_idx;

  logic                 hit, mem_ack_ok, flush_req, req_go;
  logic                 latch_req, flush_serviced, flush_done_next;
  logic                 ack_next, mem_active_next, mem_we_next;
  logic [31:0]          mem_addr_next, data_next;
  logic [WORD_SIZE-1:0] mem_data_next, src_line, merged_line;
  logic [3:0]           merge_sel;
  logic                 unused_addr_bits;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t);
    logic [31:0] n;
    n = 32'(t);
    return n << MEM_ADDR_SHIFT;
  endfunction

  assign unused_addr_bits = ^addr_i[1:0];

  // Request fields: live inputs while idle, latched copy once a transaction is underway
  always_comb begin
    cur_addr   = (state == IDLE) ? addr_i[31:2] : req_addr;
    cur_we     = (state == IDLE) ? we_i         : req_we;
    cur_sel    = (state == IDLE) ? sel_i        : req_sel;
    cur_data   = (state == IDLE) ? data_i       : req_data;
    cur_tag    = cur_addr[31:OFFSET];
    cur_idx    = cur_addr[OFFSET-1:2];
    hit        = valid && (tag == cur_tag);
    // An ack only counts while our strobe is actually up
    mem_ack_ok = mem_ack_i && mem_stb_o;
    flush_req  = flush_pending || flush_i;
    req_go     = cyc_i && stb_i && initialized_i;
    src_line   = (state == FILL) ? mem_data_i : line;
    merge_sel  = cur_we ? cur_sel : 4'b0000;
  end

  wb_line_merge #(
    .WORD_SIZE (WORD_SIZE)
  ) u_merge (
    .line     (src_line),
    .word_idx (cur_idx),
    .sel      (merge_sel),
    .data     (cur_data),
    .merged   (merged_line)
  );

  // FSM state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and control decode
  always_comb begin
    next_state      = state;
    latch_req       = 1'b0;
    flush_serviced  = 1'b0;
    flush_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req && initialized_i) begin
          if (dirty) begin
            next_state = FLUSH_WB;
          end else begin
            flush_serviced  = 1'b1;
            flush_done_next = 1'b1;
          end
        end else if (req_go) begin
          latch_req = 1'b1;
          if (hit)                next_state = RESPOND;
          else if (valid && dirty) next_state = WRITEBACK;
          else                    next_state = FILL;
        end
      end
      WRITEBACK: if (mem_ack_ok) next_state = FILL;
      FLUSH_WB: begin
        if (mem_ack_ok) begin
          next_state      = IDLE;
          flush_serviced  = 1'b1;
          flush_done_next = 1'b1;
        end
      end
      FILL:    if (mem_ack_ok) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Values the registered outputs take after this edge
  always_comb begin
    mem_active_next = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = '0;
    mem_data_next   = '0;
    data_next       = '0;
    ack_next        = (next_state == RESPOND);
    case (next_state)
      WRITEBACK, FLUSH_WB: begin
        mem_active_next = 1'b1;
        mem_we_next     = 1'b1;
        mem_addr_next   = line_addr(tag);
        mem_data_next   = line;
      end
      FILL: begin
        // Entering FILL straight from WRITEBACK leaves one strobe-low cycle
        if (state != WRITEBACK) begin
          mem_active_next = 1'b1;
          mem_addr_next   = line_addr(cur_tag);
        end
      end
      default: ;
    endcase
    if (ack_next) data_next = merged_line[32'(cur_idx) * 32 +: 32];
  end

  // Line state, request latch and registered outputs.
  // The write merge is committed on the edge entering RESPOND so the merged
  // word is already registered on data_o alongside ack_o.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      line          <= '0;
      tag           <= '0;
      valid         <= 1'b0;
      dirty         <= 1'b0;
      flush_pending <= 1'b0;
      req_addr      <= '0;
      req_we        <= 1'b0;
      req_sel       <= '0;
      req_data      <= '0;
      data_o        <= '0;
      ack_o         <= 1'b0;
      flush_done_o  <= 1'b0;
      mem_cyc_o     <= 1'b0;
      mem_stb_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
    end else begin
      flush_pending <= (flush_pending | flush_i) & ~flush_serviced;
      if (latch_req) begin
        req_addr <= addr_i[31:2];
        req_we   <= we_i;
        req_sel  <= sel_i;
        req_data <= data_i;
      end
      if ((state == WRITEBACK || state == FLUSH_WB) && mem_ack_ok) dirty <= 1'b0;
      if (state == FILL && mem_ack_ok) begin
        tag   <= cur_tag;
        valid <= 1'b1;
      end
      if (next_state == RESPOND) begin
        line  <= merged_line;
        dirty <= cur_we | (dirty & (state != FILL));
      end
      data_o       <= data_next;
      ack_o        <= ack_next;
      flush_done_o <= flush_done_next;
      mem_cyc_o    <= mem_active_next;
      mem_stb_o    <= mem_active_next;
      mem_we_o     <= mem_we_next;
      mem_addr_o   <= mem_addr_next;
      mem_data_o   <= mem_data_next;
    end
  end

endmodule

// File: tb/tb_wb_line_adapter.sv
// Directed self-checking bench for wb_line_adapter with a fixed-latency wrapper model.
module tb_wb_line_adapter;

  localparam int unsigned WORD_SIZE = 256;
  localparam int          MEM_LAT   = 3;

  logic                 sys_clk       = 1'b0;
  logic                 rst           = 1'b1;
  logic                 initialized_i = 1'b0;
  logic                 cyc_i         = 1'b0;
  logic                 stb_i         = 1'b0;
  logic                 we_i          = 1'b0;
  logic [31:0]          addr_i        = '0;
  logic [3:0]           sel_i         = '0;
  logic [31:0]          data_i        = '0;
  logic                 flush_i       = 1'b0;
  logic [WORD_SIZE-1:0] mem_data_i    = '0;
  logic                 mem_ack_i     = 1'b0;
  logic [31:0]          data_o;
  logic                 ack_o;
  logic                 flush_done_o;
  logic                 mem_cyc_o, mem_stb_o, mem_we_o;
  logic [31:0]          mem_addr_o;
  logic [WORD_SIZE-1:0] mem_data_o;

  int checks = 0;
  int errors = 0;

  logic                 mem_hold  = 1'b0;
  int                   cyc_n     = 0;
  int                   wait_cnt  = 0;
  int                   cur_start = 0;
  int                   txn_n     = 0;
  logic [31:0]          txn_addr  [16];
  logic                 txn_we    [16];
  logic [WORD_SIZE-1:0] txn_data  [16];
  int                   txn_start [16];
  int                   txn_ack   [16];

  wb_line_adapter #(
    .WORD_SIZE      (256),
    .MEM_ADDR_SHIFT (7)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .initialized_i (initialized_i),
    .cyc_i         (cyc_i),
    .stb_i         (stb_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .sel_i         (sel_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .ack_o         (ack_o),
    .flush_i       (flush_i),
    .flush_done_o  (flush_done_o),
    .mem_cyc_o     (mem_cyc_o),
    .mem_stb_o     (mem_stb_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Wrapper model: acks in the MEM_LAT-th strobed cycle and logs each transaction
  always begin
    @(posedge sys_clk);
    cyc_n++;
    #2;
    if (mem_cyc_o && mem_stb_o) begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
      end else begin
        if (wait_cnt == 0) cur_start = cyc_n;
        wait_cnt++;
        if (!mem_hold && wait_cnt >= MEM_LAT) begin
          mem_ack_i = 1'b1;
          if (txn_n < 16) begin
            txn_addr[txn_n]  = mem_addr_o;
            txn_we[txn_n]    = mem_we_o;
            txn_data[txn_n]  = mem_data_o;
            txn_start[txn_n] = cur_start;
            txn_ack[txn_n]   = cyc_n;
          end
          txn_n++;
          wait_cnt = 0;
        end
      end
    end else begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic fl);
    addr_i  = a;
    we_i    = w;
    sel_i   = s;
    data_i  = d;
    flush_i = fl;
    cyc_i   = 1'b1;
    stb_i   = 1'b1;
  endtask

  task automatic wait_ack(output logic [31:0] rd, output int lat, output int fd_at);
    logic seen;
    seen  = 1'b0;
    lat   = -1;
    fd_at = -1;
    rd    = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge sys_clk);
      #1;
      flush_i = 1'b0;
      if (flush_done_o) fd_at = i;
      if (ack_o) begin
        rd   = data_o;
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    check("ack_seen", 32'(seen), 32'h1);
    @(posedge sys_clk);
    #1;
    check("ack_one_cycle", 32'(ack_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]          rd;
    int                   lat, fd, activity;
    logic [WORD_SIZE-1:0] exp_line;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ack",        32'(ack_o),        32'h0);
    check("rst_data",       data_o,            32'h0);
    check("rst_flush_done", 32'(flush_done_o), 32'h0);
    check("rst_mem_cyc",    32'(mem_cyc_o),    32'h0);
    check("rst_mem_stb",    32'(mem_stb_o),    32'h0);
    check("rst_mem_we",     32'(mem_we_o),     32'h0);
    check("rst_mem_addr",   mem_addr_o,        32'h0);
    check("rst_mem_data0",  mem_data_o[31:0],  32'h0);
    @(posedge sys_clk);
    #1;
    rst           = 1'b0;
    initialized_i = 1'b1;

    // Cold read miss: single clean fill of line 0
    mem_data_i = {32{8'hA5}};
    start_req(32'h0000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    wait_ack(rd, lat, fd);
    check("fill_rdata",     rd,             32'hA5A5_A5A5);
    check("clean_miss_lat", lat,            MEM_LAT + 1);
    check("fill_txn_count", txn_n,          1);
    check("fill_addr",      txn_addr[0],    32'h0);
    check("fill_we",        32'(txn_we[0]), 32'h0);

    // Partial write hit then read-back
    start_req(32'h0000_0004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0);
    wait_ack(rd, lat, fd);
    check("wr_merged",  rd,  32'hA5A5_BEEF);
    check("wr_hit_lat", lat, 1);
    start_req(32'h0000_0004, 1'b0, 4'h0, 32'h0, 1'b0);
    wait_ack(rd, lat, fd);
    check("rd_hit_data",    rd,    32'hA5A5_BEEF);
    check("rd_hit_lat",     lat,   1);
    check("hit_no_traffic", txn_n, 1);

    // Dirty miss: write-back of line 0, one idle cycle, fill of line 1
    mem_data_i = {8{32'h0123_4567}};
    start_req(32'h0000_0020, 1'b0, 4'h0, 32'h0, 1'b0);
    wait_ack(rd, lat, fd);
    check("dm_rdata",     rd,    32'h0123_4567);
    check("dm_lat",       lat,   2 * MEM_LAT + 2);
    check("dm_txn_count", txn_n, 3);
    check("wb_we",        32'(txn_we[1]), 32'h1);
    check("wb_addr",      txn_addr[1],    32'h0);
    exp_line          = {32{8'hA5}};
    exp_line[63:32]   = 32'hA5A5_BEEF;
    for (int w = 0; w < 8; w++)
      check($sformatf("wb_word%0d", w), txn_data[1][w * 32 +: 32], exp_line[w * 32 +: 32]);
    check("refill_we",   32'(txn_we[2]), 32'h0);
    check("refill_addr", txn_addr[2],    32'h80);
    check("wb_fill_gap", txn_start[2] - txn_ack[1], 2);

    // Dirty line, flush together with a read: flush served first
    start_req(32'h0000_0024, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0);
    wait_ack(rd, lat, fd);
    check("wr2_data",    rd,  32'hCAFE_F00D);
    check("wr2_hit_lat", lat, 1);
    start_req(32'h0000_0028, 1'b0, 4'h0, 32'h0, 1'b1);
    wait_ack(rd, lat, fd);
    check("flush_done_at",  fd,    MEM_LAT + 1);
    check("flush_req_lat",  lat,   MEM_LAT + 2);
    check("flush_req_data", rd,    32'h0123_4567);
    check("flush_txn_cnt",  txn_n, 4);
    check("flush_wb_we",    32'(txn_we[3]), 32'h1);
    check("flush_wb_addr",  txn_addr[3],    32'h80);
    check("flush_wb_word0", txn_data[3][31:0],  32'h0123_4567);
    check("flush_wb_word1", txn_data[3][63:32], 32'hCAFE_F00D);

    // Flush of a clean line: pulse only, no traffic
    flush_i = 1'b1;
    @(posedge sys_clk);
    #1;
    flush_i = 1'b0;
    check("clean_flush_done", 32'(flush_done_o), 32'h1);
    @(posedge sys_clk);
    #1;
    check("clean_flush_width", 32'(flush_done_o), 32'h0);
    check("clean_flush_txns",  txn_n,             4);

    // Reset while the fill is outstanding
    mem_hold   = 1'b1;
    mem_data_i = {8{32'h5555_AAAA}};
    start_req(32'h0000_0100, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("hold_stb",  32'(mem_stb_o), 32'h1);
    check("hold_addr", mem_addr_o,     32'h400);
    rst   = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    #1;
    check("arst_mem_cyc",  32'(mem_cyc_o), 32'h0);
    check("arst_mem_stb",  32'(mem_stb_o), 32'h0);
    check("arst_mem_addr", mem_addr_o,     32'h0);
    check("arst_ack",      32'(ack_o),     32'h0);
    @(posedge sys_clk);
    #1;
    rst      = 1'b0;
    mem_hold = 1'b0;
    start_req(32'h0000_0100, 1'b0, 4'h0, 32'h0, 1'b0);
    wait_ack(rd, lat, fd);
    check("post_rst_data",  rd,          32'h5555_AAAA);
    check("post_rst_lat",   lat,         MEM_LAT + 1);
    check("post_rst_txns",  txn_n,       5);
    check("post_rst_addr",  txn_addr[4], 32'h400);

    // Calibration low: request stalls with no traffic, then completes
    initialized_i = 1'b0;
    mem_data_i    = {8{32'h0F0F_F0F0}};
    start_req(32'h0000_0200, 1'b0, 4'h0, 32'h0, 1'b0);
    activity = 0;
    repeat (50) begin
      @(posedge sys_clk);
      #1;
      if (mem_cyc_o || mem_stb_o || ack_o) activity++;
    end
    check("stall_activity", activity, 0);
    initialized_i = 1'b1;
    wait_ack(rd, lat, fd);
    check("stall_rdata", rd,          32'h0F0F_F0F0);
    check("stall_lat",   lat,         MEM_LAT + 1);
    check("stall_txns",  txn_n,       6);
    check("stall_addr",  txn_addr[5], 32'h800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
